// File: rtl/fp_pkg.sv
// Shared FP register-file types: default geometry, register address and
// double-precision (even/odd pair) data word.
package fp_pkg;
  localparam int FP_WIDTH = 32;
  localparam int FP_DEPTH = 32;
  typedef logic [4:0]  fpreg_addr_t;
  typedef logic [63:0] fp_dbl_t;
endpackage

// File: rtl/fp_regfile_sb_if.sv
// Decode / writeback bus of the FP register file: writeback, issue marking
// and the packed N-port read side.
interface fp_regfile_sb_if import fp_pkg::*; #(
  parameter int WIDTH = FP_WIDTH,
  parameter int DEPTH = FP_DEPTH,
  parameter int NREAD = 2
) ();
  localparam int AW = $clog2(DEPTH);

  logic                       we;
  logic [AW-1:0]              wa;
  logic                       wdbl;
  logic [2*WIDTH-1:0]         wd;
  logic [NREAD*AW-1:0]        ra;
  logic [NREAD-1:0]           rdbl;
  logic [NREAD*2*WIDTH-1:0]   rd;
  logic [NREAD-1:0]           rbusy;
  logic                       iss_v;
  logic [AW-1:0]              iss_a;
  logic                       iss_dbl;
  logic                       err;

  modport master (output we, wa, wdbl, wd, ra, rdbl, iss_v, iss_a, iss_dbl,
                  input  rd, rbusy, err);
  modport slave  (input  we, wa, wdbl, wd, ra, rdbl, iss_v, iss_a, iss_dbl,
                  output rd, rbusy, err);
endinterface

// File: rtl/fp_scoreboard.sv
// Per-register busy tracking: issue sets, writeback clears (issue wins on the
// same edge), sticky error for misalignment and WAW re-issue.
module fp_scoreboard import fp_pkg::*; #(
  parameter int DEPTH    = FP_DEPTH,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_lo,
  input  logic             clr_hi,
  input  logic [AW-1:0]    wa,
  input  logic             wr_mis,
  input  logic             iss_v,
  input  logic [AW-1:0]    iss_a,
  input  logic             iss_dbl,
  output logic [DEPTH-1:0] busy,
  output logic             err
);
  logic [DEPTH-1:0] busy_q, busy_d, set_m, clr_m;
  logic             err_q, err_d, iss_mis;

  always_comb begin
    set_m   = '0;
    clr_m   = '0;
    iss_mis = iss_v & iss_dbl & iss_a[0];
    if (clr_lo) clr_m[wa] = 1'b1;
    if (clr_hi) clr_m[{wa[AW-1:1], 1'b1}] = 1'b1;
    if (iss_v && !iss_mis) begin
      if (!(ZERO_REG && iss_a == '0)) set_m[iss_a] = 1'b1;
      if (iss_dbl) set_m[{iss_a[AW-1:1], 1'b1}] = 1'b1;
    end
    // set is OR'd last so a coincident issue leaves the register pending
    busy_d = (busy_q & ~clr_m) | set_m;
    err_d  = err_q | wr_mis | iss_mis | (|(busy_q & set_m));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy = busy_q;
  assign err  = err_q;
endmodule

// File: rtl/fp_regfile_sb.sv
// Parametrised FP register file: N combinational read ports with single or
// even/odd pair access, optional write-through bypass and busy scoreboard.
module fp_regfile_sb import fp_pkg::*; #(
  parameter int WIDTH    = FP_WIDTH,
  parameter int DEPTH    = FP_DEPTH,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  fp_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [AW-1:0]               wa_hi;
  logic                        wr_mis, wr_lo, wr_hi;
  logic [DEPTH-1:0]            busy;
  logic                        err;

  always_comb begin
    wa_hi  = {bus.wa[AW-1:1], 1'b1};
    wr_mis = bus.we & bus.wdbl & bus.wa[0];
    wr_lo  = bus.we & ~wr_mis & ~(ZERO_REG && bus.wa == '0);
    wr_hi  = bus.we & bus.wdbl & ~wr_mis;
    regs_d = regs_q;
    if (wr_lo) regs_d[bus.wa] = bus.wd[WIDTH-1:0];
    if (wr_hi) regs_d[wa_hi]  = bus.wd[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  fp_scoreboard #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_sb (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_lo  (wr_lo),
    .clr_hi  (wr_hi),
    .wa      (bus.wa),
    .wr_mis  (wr_mis),
    .iss_v   (bus.iss_v),
    .iss_a   (bus.iss_a),
    .iss_dbl (bus.iss_dbl),
    .busy    (busy),
    .err     (err)
  );

  assign bus.err = err;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    a_lo, a_hi;
    logic             dbl, mis;
    logic [WIDTH-1:0] d_lo, d_hi;

    always_comb begin
      a_lo = bus.ra[i*AW +: AW];
      a_hi = {a_lo[AW-1:1], 1'b1};
      dbl  = bus.rdbl[i];
      mis  = dbl & a_lo[0];
      d_lo = regs_q[a_lo];
      d_hi = regs_q[a_hi];
      // forward whichever writeback half lands on the addressed register
      if (BYPASS && wr_lo && bus.wa == a_lo) d_lo = bus.wd[WIDTH-1:0];
      if (BYPASS && wr_hi && wa_hi  == a_lo) d_lo = bus.wd[2*WIDTH-1:WIDTH];
      if (BYPASS && wr_lo && bus.wa == a_hi) d_hi = bus.wd[WIDTH-1:0];
      if (BYPASS && wr_hi && wa_hi  == a_hi) d_hi = bus.wd[2*WIDTH-1:WIDTH];
      if (ZERO_REG && a_lo == '0) d_lo = '0;
      if (!dbl) d_hi = '0;
      if (mis) begin
        d_lo = '0;
        d_hi = '0;
      end
    end

    assign bus.rd[i*2*WIDTH +: 2*WIDTH] = {d_hi, d_lo};
    assign bus.rbusy[i] = ~mis & (busy[a_lo] | (dbl & busy[a_hi]));
  end
endmodule

// File: tb/tb_fp_regfile_sb.sv
// Scenario bench for fp_regfile_sb (BYPASS=1, ZERO_REG=1): expectations are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_fp_regfile_sb;
  import fp_pkg::*;
  localparam int W = FP_WIDTH, D = FP_DEPTH, NR = 2, AW = 5;

  logic    clk = 1'b0, reset_n = 1'b0;
  int      total = 0, bad = 0;
  fp_dbl_t exp_q[$];

  always #5 clk = ~clk;

  fp_regfile_sb_if #(.WIDTH(W), .DEPTH(D), .NREAD(NR)) bus ();
  fp_regfile_sb #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  task automatic idle();
    bus.we = 0; bus.wa = '0; bus.wdbl = 0; bus.wd = '0;
    bus.iss_v = 0; bus.iss_a = '0; bus.iss_dbl = 0;
  endtask

  task automatic rd_set(input int p, input fpreg_addr_t a, input logic dbl);
    bus.ra[p*AW +: AW] = a;
    bus.rdbl[p] = dbl;
  endtask

  function automatic fp_dbl_t rdp(input int p);
    return bus.rd[p*64 +: 64];
  endfunction

  task automatic reset_dut();
    @(negedge clk); idle(); reset_n = 0; #1; reset_n = 1;
  endtask

  task automatic test_reset();
    fp_dbl_t e;
    reset_n = 0; idle(); bus.we = 1; bus.wa = 5'd3; bus.wd = 64'hFF;
    bus.iss_v = 1; bus.iss_a = 5'd3;
    @(posedge clk); @(negedge clk); idle();
    for (int a = 0; a < D; a++) begin
      rd_set(0, fpreg_addr_t'(a), 1'b0);
      rd_set(1, fpreg_addr_t'(a & 30), 1'b1);
      #1;
      exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
      e = exp_q.pop_front(); total++;
      if (rdp(0) !== e) begin bad++; $display("FAIL reset_rd0 a=%0d got=%h exp=%h", a, rdp(0), e); end
      e = exp_q.pop_front(); total++;
      if (rdp(1) !== e) begin bad++; $display("FAIL reset_rd1 a=%0d got=%h exp=%h", a, rdp(1), e); end
      e = exp_q.pop_front(); total++;
      if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL reset_rbusy a=%0d got=%b exp=%0d", a, bus.rbusy, e); end
    end
    exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL reset_err got=%b exp=%0d", bus.err, e); end
    reset_n = 1;
  endtask

  task automatic test_bypass();
    fp_dbl_t e;
    @(negedge clk); idle();
    bus.we = 1; bus.wa = 5'd4; bus.wd = 64'h3F800000;
    rd_set(0, 5'd4, 1'b0); rd_set(1, 5'd4, 1'b1);
    #1;
    exp_q.push_back(64'h3F800000); exp_q.push_back(64'h00000000_3F800000);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL bypass_single got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if (rdp(1) !== e) begin bad++; $display("FAIL bypass_pair got=%h exp=%h", rdp(1), e); end
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'h3F800000);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL bypass_stored got=%h exp=%h", rdp(0), e); end
  endtask

  task automatic test_double();
    fp_dbl_t e;
    @(negedge clk); idle();
    bus.we = 1; bus.wa = 5'd6; bus.wdbl = 1; bus.wd = 64'h40000000_3F800000;
    rd_set(0, 5'd6, 1'b1); #1;
    exp_q.push_back(64'h40000000_3F800000);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL dbl_bypass got=%h exp=%h", rdp(0), e); end
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'h40000000_3F800000); exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL dbl_read got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL dbl_err0 got=%b exp=%0d", bus.err, e); end
    @(negedge clk);
    bus.we = 1; bus.wa = 5'd7; bus.wdbl = 1; bus.wd = 64'hDEADBEEF_CAFEF00D; #1;
    exp_q.push_back(64'h40000000_3F800000);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL mis_no_bypass got=%h exp=%h", rdp(0), e); end
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'h40000000_3F800000); exp_q.push_back(64'd1);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL mis_unchanged got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL mis_wr_err got=%b exp=%0d", bus.err, e); end
    rd_set(0, 5'd7, 1'b1); rd_set(1, 5'd7, 1'b0); #1;
    exp_q.push_back(64'd0); exp_q.push_back(64'h40000000);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL mis_read got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if (rdp(1) !== e) begin bad++; $display("FAIL odd_single got=%h exp=%h", rdp(1), e); end
  endtask

  task automatic test_scoreboard();
    fp_dbl_t e;
    reset_dut();
    @(negedge clk); bus.iss_v = 1; bus.iss_a = 5'd8;
    rd_set(0, 5'd8, 1'b0); rd_set(1, 5'd8, 1'b1); #1;
    exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL sb_pre got=%b exp=%0d", bus.rbusy, e); end
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'd3);
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL sb_marked got=%b exp=%0d", bus.rbusy, e); end
    @(negedge clk); bus.we = 1; bus.wa = 5'd8; bus.wd = 64'h1234;
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'd0); exp_q.push_back(64'h1234); exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL sb_cleared got=%b exp=%0d", bus.rbusy, e); end
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL sb_wb_data got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL sb_no_err got=%b exp=%0d", bus.err, e); end
    @(negedge clk); bus.iss_v = 1; bus.iss_a = 5'd8;
    @(negedge clk); #1;
    exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL sb_first_iss_err got=%b exp=%0d", bus.err, e); end
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'd1); exp_q.push_back(64'd3);
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL sb_waw_err got=%b exp=%0d", bus.err, e); end
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL sb_waw_busy got=%b exp=%0d", bus.rbusy, e); end
    reset_dut();
    @(negedge clk); bus.iss_v = 1; bus.iss_a = 5'd9; bus.iss_dbl = 1;
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'd0); exp_q.push_back(64'd1);
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL mis_iss_busy got=%b exp=%0d", bus.rbusy, e); end
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL mis_iss_err got=%b exp=%0d", bus.err, e); end
  endtask

  task automatic test_same_edge();
    fp_dbl_t e;
    reset_dut();
    @(negedge clk); bus.iss_v = 1; bus.iss_a = 5'd10; bus.we = 1; bus.wa = 5'd10; bus.wd = 64'h5;
    rd_set(0, 5'd10, 1'b0); rd_set(1, 5'd13, 1'b0);
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'h5); exp_q.push_back(64'd1); exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL same_data got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL same_busy got=%b exp=%0d", bus.rbusy, e); end
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL same_err got=%b exp=%0d", bus.err, e); end
    @(negedge clk); bus.iss_v = 1; bus.iss_a = 5'd12; bus.iss_dbl = 1;
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'd3);
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL pair_busy got=%b exp=%0d", bus.rbusy, e); end
    @(negedge clk); bus.we = 1; bus.wa = 5'd12; bus.wdbl = 1; bus.wd = 64'h77_00000066;
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'd1); exp_q.push_back(64'h77);
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL pair_clear got=%b exp=%0d", bus.rbusy, e); end
    e = exp_q.pop_front(); total++;
    if (rdp(1) !== e) begin bad++; $display("FAIL pair_hi_data got=%h exp=%h", rdp(1), e); end
  endtask

  task automatic test_zero_and_async_reset();
    fp_dbl_t e;
    reset_dut();
    @(negedge clk); bus.we = 1; bus.wa = 5'd0; bus.wdbl = 1; bus.wd = 64'hAAAA0000_0000BBBB;
    rd_set(0, 5'd0, 1'b1); rd_set(1, 5'd0, 1'b0); #1;
    exp_q.push_back(64'hAAAA0000_00000000);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL zero_bypass got=%h exp=%h", rdp(0), e); end
    @(negedge clk); idle(); bus.iss_v = 1; bus.iss_a = 5'd0; #1;
    exp_q.push_back(64'hAAAA0000_00000000); exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL zero_pair got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if (rdp(1) !== e) begin bad++; $display("FAIL zero_single got=%h exp=%h", rdp(1), e); end
    @(negedge clk); idle(); #1;
    exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL zero_busy got=%b exp=%0d", bus.rbusy, e); end
    @(negedge clk); bus.iss_v = 1; bus.iss_a = 5'd14;
    @(negedge clk); idle(); bus.we = 1; bus.wa = 5'd16; bus.wd = 64'h77;
    @(negedge clk); idle(); bus.iss_v = 1; bus.iss_a = 5'd3; bus.iss_dbl = 1;
    @(negedge clk); idle(); rd_set(0, 5'd16, 1'b0); rd_set(1, 5'd14, 1'b0); #1;
    exp_q.push_back(64'h77); exp_q.push_back(64'd2); exp_q.push_back(64'd1);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL pre_rst_data got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL pre_rst_busy got=%b exp=%0d", bus.rbusy, e); end
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL pre_rst_err got=%b exp=%0d", bus.err, e); end
    #1 reset_n = 0; #1;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL async_rst_data got=%h exp=%h", rdp(0), e); end
    e = exp_q.pop_front(); total++;
    if ({62'd0, bus.rbusy} !== e) begin bad++; $display("FAIL async_rst_busy got=%b exp=%0d", bus.rbusy, e); end
    e = exp_q.pop_front(); total++;
    if ({63'd0, bus.err} !== e) begin bad++; $display("FAIL async_rst_err got=%b exp=%0d", bus.err, e); end
    bus.we = 1; bus.wa = 5'd16; bus.wd = 64'h99;
    @(negedge clk); idle(); reset_n = 1; #1;
    exp_q.push_back(64'd0);
    e = exp_q.pop_front(); total++;
    if (rdp(0) !== e) begin bad++; $display("FAIL rst_write_dropped got=%h exp=%h", rdp(0), e); end
  endtask

  task automatic test_back_to_back();
    fp_dbl_t     e;
    logic [31:0] m [D];
    logic [31:0] v;
    reset_dut();
    for (int a = 0; a < D; a++) m[a] = '0;
    for (int a = 1; a < D; a++) begin
      @(negedge clk);
      v = $urandom;
      bus.we = 1; bus.wa = fpreg_addr_t'(a); bus.wdbl = 0; bus.wd = {32'hFFFF_FFFF, v};
      m[a] = v;
      rd_set(1, fpreg_addr_t'(a), 1'b0); #1;
      exp_q.push_back({32'd0, m[a]});
      e = exp_q.pop_front(); total++;
      if (rdp(1) !== e) begin bad++; $display("FAIL b2b_bypass a=%0d got=%h exp=%h", a, rdp(1), e); end
    end
    @(negedge clk); idle();
    for (int a = 0; a < D; a += 2) begin
      rd_set(0, fpreg_addr_t'(a), 1'b1); #1;
      exp_q.push_back({m[a+1], m[a]});
      e = exp_q.pop_front(); total++;
      if (rdp(0) !== e) begin bad++; $display("FAIL b2b_pair a=%0d got=%h exp=%h", a, rdp(0), e); end
    end
  endtask

  initial begin
    idle(); bus.ra = '0; bus.rdbl = '0;
    test_reset();
    test_bypass();
    test_double();
    test_scoreboard();
    test_same_edge();
    test_zero_and_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
Parametrised successor to the single-precision FP register file. Adds an N-read-port array, single/double (even/odd pair) access, optional write-through bypass, asynchronous clear and a per-register busy scoreboard. Sits in the FP datapath between decode (reads, issue marking) and the multi-cycle FP unit writeback. Replaces the fixed 32x32, 2-read, falling-edge-write file.

Parameters:
WIDTH, 32, bits per register
DEPTH, 32, number of registers; must be even, >= 4
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
we  in  1  writeback enable
wa  in  AW  writeback address; AW = $clog2(DEPTH)
wdbl  in  1  writeback is double (pair wa, wa+1)
wd  in  2*WIDTH  writeback data; [WIDTH-1:0] -> wa, [2W-1:W] -> wa+1 (double only)
ra  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
rdbl  in  NREAD  per-port double read
rd  out  NREAD*2*WIDTH  packed read data, port i at [i*2W +: 2W]
rbusy  out  NREAD  per-port: any addressed register has a pending write
iss_v  in  1  issue marks a destination pending
iss_a  in  AW  issue destination
iss_dbl  in  1  issue destination is a pair
err  out  1  sticky error flag

Behaviour:
- Reset (reset_n low, async): all registers 0, all busy bits 0, err 0. Outputs then follow as combinational functions of cleared state; rd = 0, rbusy = 0.
- Write: on rising edge with we=1, reg[wa] <= wd[W-1:0]. If wdbl=1, also reg[wa+1] <= wd[2W-1:W]. Same edge clears busy of every written register.
- Double alignment: wdbl/iss_dbl/rdbl with address bit 0 = 1 is misaligned.
  - Misaligned write: no register written, no busy cleared.
  - Misaligned issue: nothing marked.
  - Misaligned read: rd port = 0, rbusy = 0.
  - Any misaligned write/issue sets err (sticky until reset). Reads never set err.
- Read (combinational, 0 cycle): single -> rd = {W'0, reg[ra]}; double -> rd = {reg[ra+1], reg[ra]}.
- BYPASS=1: if we=1 and a written register matches a read register in the same cycle, wd's corresponding half is returned instead of the array value. BYPASS=0: old value until next cycle.
- ZERO_REG=1:
  - Register 0 always reads 0 (also via bypass).
  - Writes to register 0 are dropped; a double write to pair 0/1 still writes reg 1.
  - Register 0 is never busy.
- Scoreboard:
  - Rising edge with iss_v=1 sets busy[iss_a] (and busy[iss_a+1] if iss_dbl).
  - rbusy[i] = OR of busy bits of the registers addressed by port i (1 or 2).
  - Issue to an already-busy register keeps busy=1 and sets err (WAW hazard).
  - Issue and writeback to the same register on the same edge: issue wins, busy ends 1, data is written, err not set.
  - Writeback to a non-busy register writes data without error.
- Reset asserted mid-operation: immediate clear; any pending busy state is lost; a coincident write is discarded.

Decomposition:
- Shared package fp_pkg: FP_WIDTH=32, FP_DEPTH=32, typedef fpreg_addr_t (logic [4:0]), typedef fp_dbl_t (logic [63:0]).
- One sub-module: fp_scoreboard (busy vector, issue/clear priority, WAW err). Array, bypass and read muxing stay in fp_regfile_sb.

Test Plan:
- Reset then read all ports at addrs 0..31 -> rd=0, rbusy=0, err=0.
- we=1, wa=4, wd[31:0]=0x3F800000 with ra0=4 same cycle: BYPASS=1 -> rd0=0x3F800000. BYPASS=0 -> 0 that cycle, 0x3F800000 next.
- Double write wa=6, wd=0x40000000_3F800000; rdbl0=1, ra0=6 next cycle -> rd0=0x40000000_3F800000. Then wa=7, wdbl=1 -> err=1, regs 6/7 unchanged.
- iss_v=1, iss_a=8 -> rbusy for ra=8 is 1. Writeback wa=8 -> rbusy 0 next cycle. Re-issue 8 twice without writeback -> err=1.
- Same edge: iss_a=10 and we with wa=10, wd=0x5 -> reg10=0x5, busy[10]=1, err=0.
- ZERO_REG=1: double write wa=0, wd=0xAAAA_BBBB -> rdbl read at 0 gives 0xAAAA0000_00000000 (upper=0xAAAA, lower=0). iss_a=0 -> rbusy 0. Assert reset_n low mid-sequence -> all cleared immediately.
